// File: rtl/sys_defs.sv
// Shared sizes and packet types for the writeback/complete stage and its neighbours.
package sys_defs;

   localparam int N_FU_UNITS = 7;
   localparam int N_WB_LANES = 3;
   localparam int N_PHYS_REG = 64;
   localparam int PREG_W     = 6;
   localparam int ROB_W      = 5;
   localparam int XLEN       = 32;

   // Finished result as produced by a functional unit.
   typedef struct packed {
      logic [PREG_W-1:0] preg;
      logic [ROB_W-1:0]  rob;
      logic [XLEN-1:0]   value;
   } FU_RESULT_PACKET;

   // Common data bus broadcast: RS wakeup and ROB completion.
   typedef struct packed {
      logic              valid;
      logic [PREG_W-1:0] preg;
      logic [ROB_W-1:0]  rob;
   } CDB_PACKET;

   // PRF write port packet; idx 0 means no write.
   typedef struct packed {
      logic [PREG_W-1:0] idx;
      logic [XLEN-1:0]   value;
   } FU_PRF_PACKET;

   // Bring an index that has stepped at most one period past m back into 0..m-1.
   function automatic int wrap_idx(input int v, input int m);
      return (v >= m) ? (v - m) : v;
   endfunction

endpackage

// File: rtl/complete_stage_checker.sv
// Protocol and output invariants for complete_stage, bound alongside it.
module complete_stage_checker
   import sys_defs::*;
#(
   parameter int N_FU = N_FU_UNITS,
   parameter int N_WB = N_WB_LANES
) (
   input logic            clock,
   input logic            reset,
   input logic            squash,
   input logic [N_FU-1:0] fu_valid,
   input logic [N_FU-1:0] fu_ready,
   input FU_RESULT_PACKET fu_result [N_FU],
   input CDB_PACKET       cdb_out   [N_WB]
);

   // Two lanes never write the same real destination in one cycle.
   for (genvar j = 0; j < N_WB; j++) begin : g_lane_a
      for (genvar k = j + 1; k < N_WB; k++) begin : g_lane_b
         a_unique_preg: assert property (@(posedge clock) disable iff (reset)
            !(cdb_out[j].valid && cdb_out[k].valid &&
              (cdb_out[j].preg != '0) && (cdb_out[j].preg == cdb_out[k].preg)));
      end
   end

   // A stalled FU keeps its result stable until it is taken.
   for (genvar i = 0; i < N_FU; i++) begin : g_fu
      a_stable: assert property (@(posedge clock) disable iff (reset)
         (fu_valid[i] && !fu_ready[i] && !squash && !reset) |=> $stable(fu_result[i]));
   end

endmodule

// File: rtl/complete_stage_rr_picker.sv
// N-of-M rotating-priority selector: grants the first N requesters found when
// scanning from ptr_i upward (mod M) and reports them lane by lane in scan order.
module rr_picker
   import sys_defs::*;
#(
   parameter int M     = 7,
   parameter int N     = 3,
   parameter int IDX_W = (M > 1) ? $clog2(M) : 1
) (
   input  logic [M-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [M-1:0]     grant_o,
   output logic [N-1:0]     lane_valid_o,
   output logic [IDX_W-1:0] lane_idx_o [N],
   output logic             any_grant_o,
   output logic [IDX_W-1:0] next_ptr_o
);

   // Scan all requesters once from the pointer, filling lanes in order.
   always_comb begin
      int               cnt;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] last;
      grant_o      = '0;
      lane_valid_o = '0;
      for (int j = 0; j < N; j++) begin
         lane_idx_o[j] = '0;
      end
      cnt  = 0;
      idx  = '0;
      last = '0;
      for (int k = 0; k < M; k++) begin
         idx = IDX_W'(wrap_idx(int'(ptr_i) + k, M));
         if (req_i[idx] && (cnt < N)) begin
            grant_o[idx] = 1'b1;
            for (int j = 0; j < N; j++) begin
               if (j == cnt) begin
                  lane_valid_o[j] = 1'b1;
                  lane_idx_o[j]   = idx;
               end else begin
                  lane_valid_o[j] = lane_valid_o[j];
               end
            end
            last = idx;
            cnt  = cnt + 1;
         end else begin
            last = last;
         end
      end
      any_grant_o = (cnt != 0);
      next_ptr_o  = IDX_W'(wrap_idx(int'(last) + 1, M));
   end

endmodule

// File: rtl/complete_stage.sv
// Writeback/complete stage: one-entry result slot per FU, round-robin drain of
// up to N_WB slots per cycle onto PRF write packets and CDB broadcasts.
module complete_stage
   import sys_defs::*;
#(
   parameter int N_FU = N_FU_UNITS,
   parameter int N_WB = N_WB_LANES
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            squash,
   input  logic [N_FU-1:0] fu_valid,
   input  FU_RESULT_PACKET fu_result  [N_FU],
   output logic [N_FU-1:0] fu_ready,
   output FU_PRF_PACKET    wb_prf_out [N_WB],
   output CDB_PACKET       cdb_out    [N_WB]
);

   localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

   logic [N_FU-1:0]  occ_q, occ_d;
   FU_RESULT_PACKET  slot_q [N_FU];
   FU_RESULT_PACKET  slot_d [N_FU];
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             flush_s;
   logic [N_FU-1:0]  pick_grant_s;
   logic [N_FU-1:0]  grant_s;
   logic [N_FU-1:0]  accept_s;
   logic [N_WB-1:0]  lane_valid_s;
   logic [IDX_W-1:0] lane_idx_s [N_WB];
   logic             any_grant_s;
   logic [IDX_W-1:0] next_ptr_s;

   assign flush_s  = reset | squash;
   assign grant_s  = pick_grant_s & {N_FU{~flush_s}};
   assign fu_ready = {N_FU{~flush_s}} & (~occ_q | grant_s);
   assign accept_s = fu_valid & fu_ready;

   rr_picker #(.M(N_FU), .N(N_WB), .IDX_W(IDX_W)) u_picker (
      .req_i        (occ_q),
      .ptr_i        (rr_ptr_q),
      .grant_o      (pick_grant_s),
      .lane_valid_o (lane_valid_s),
      .lane_idx_o   (lane_idx_s),
      .any_grant_o  (any_grant_s),
      .next_ptr_o   (next_ptr_s)
   );

   // Next slot/pointer state: a refill wins over a drain of the same slot.
   always_comb begin
      occ_d    = occ_q;
      slot_d   = slot_q;
      rr_ptr_d = rr_ptr_q;
      if (flush_s) begin
         occ_d    = '0;
         rr_ptr_d = '0;
      end else begin
         for (int i = 0; i < N_FU; i++) begin
            if (accept_s[i]) begin
               occ_d[i]  = 1'b1;
               slot_d[i] = fu_result[i];
            end else if (grant_s[i]) begin
               occ_d[i] = 1'b0;
            end else begin
               occ_d[i] = occ_q[i];
            end
         end
         if (any_grant_s) begin
            rr_ptr_d = next_ptr_s;
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end
   end

   // Occupancy and pointer registers, cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         occ_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         occ_q    <= occ_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Slot payload registers; contents only matter while the slot is occupied.
   always_ff @(posedge clock) begin
      slot_q <= slot_d;
   end

   // Lane outputs straight from the granted slots; idle lanes are all zero.
   always_comb begin
      for (int j = 0; j < N_WB; j++) begin
         if (lane_valid_s[j] && !flush_s) begin
            cdb_out[j].valid    = 1'b1;
            cdb_out[j].preg     = slot_q[lane_idx_s[j]].preg;
            cdb_out[j].rob      = slot_q[lane_idx_s[j]].rob;
            wb_prf_out[j].idx   = slot_q[lane_idx_s[j]].preg;
            wb_prf_out[j].value = slot_q[lane_idx_s[j]].value;
         end else begin
            cdb_out[j]    = '0;
            wb_prf_out[j] = '0;
         end
      end
   end

endmodule

// File: tb/tb_complete_stage.sv
// Self-checking bench for complete_stage: behavioural slot/round-robin model,
// rob-index scoreboard, directed scenarios and randomized traffic with squashes.
`timescale 1ns/1ps
module tb_complete_stage;
   import sys_defs::*;

   localparam int NF = N_FU_UNITS;
   localparam int NW = N_WB_LANES;
   localparam int CW = $bits(CDB_PACKET);
   localparam int WW = $bits(FU_PRF_PACKET);

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            squash = 1'b0;
   logic [NF-1:0]   fu_valid = '0;
   FU_RESULT_PACKET fu_result [NF];
   logic [NF-1:0]   fu_ready;
   FU_PRF_PACKET    wb_prf_out [NW];
   CDB_PACKET       cdb_out [NW];

   always #5 clock = ~clock;

   complete_stage #(.N_FU(NF), .N_WB(NW)) dut (
      .clock(clock), .reset(reset), .squash(squash),
      .fu_valid(fu_valid), .fu_result(fu_result), .fu_ready(fu_ready),
      .wb_prf_out(wb_prf_out), .cdb_out(cdb_out)
   );

   complete_stage_checker #(.N_FU(NF), .N_WB(NW)) u_chk (
      .clock(clock), .reset(reset), .squash(squash),
      .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_result(fu_result), .cdb_out(cdb_out)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: which FU results are buffered, their contents, the scan start.
   bit              m_occ [NF];
   FU_RESULT_PACKET m_slot [NF];
   int              m_ptr = 0;
   bit              acc [NF];
   int              pend [32];
   logic [XLEN-1:0] prf [N_PHYS_REG];
   logic [127:0]    last_e_cdb;
   logic [NF-1:0]   last_e_rdy;
   int              next_rob = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle reference: compare DUT against the model, then advance the model.
   always @(negedge clock) begin : compare
      int            g[$];
      bit            granted [NF];
      bit            flush;
      logic [127:0]  a_cdb, a_wb, e_cdb, e_wb;
      logic [NF-1:0] e_rdy;
      int            k;
      int            r;
      flush = reset || squash;
      g.delete();
      for (int i = 0; i < NF; i++) granted[i] = 1'b0;
      if (!flush) begin
         for (int s = 0; s < NF; s++) begin
            k = (m_ptr + s) % NF;
            if (m_occ[k] && g.size() < NW) begin
               g.push_back(k);
               granted[k] = 1'b1;
            end
         end
      end
      a_cdb = '0; a_wb = '0; e_cdb = '0; e_wb = '0;
      for (int j = 0; j < NW; j++) begin
         a_cdb[j*CW +: CW] = cdb_out[j];
         a_wb[j*WW +: WW]  = wb_prf_out[j];
         if (j < g.size()) begin
            e_cdb[j*CW +: CW] = {1'b1, m_slot[g[j]].preg, m_slot[g[j]].rob};
            e_wb[j*WW +: WW]  = {m_slot[g[j]].preg, m_slot[g[j]].value};
         end
      end
      for (int i = 0; i < NF; i++) e_rdy[i] = !flush && (!m_occ[i] || granted[i]);
      chk("cdb", a_cdb, e_cdb);
      chk("wb", a_wb, e_wb);
      chk("fu_ready", {121'd0, fu_ready}, {121'd0, e_rdy});
      last_e_cdb = e_cdb;
      last_e_rdy = e_rdy;
      // Every broadcast rob index must match exactly one outstanding accepted result.
      for (int j = 0; j < NW; j++) begin
         if (cdb_out[j].valid === 1'b1) begin
            r = int'(cdb_out[j].rob);
            n_checks++;
            if (pend[r] <= 0) begin
               n_fail++;
               $display("FAIL sb_rob: rob %0d broadcast with %0d outstanding, required >=1", r, pend[r]);
            end else begin
               pend[r]--;
            end
         end
         if (!flush && wb_prf_out[j].idx != '0) prf[wb_prf_out[j].idx] = wb_prf_out[j].value;
      end
      if (flush) begin
         for (int i = 0; i < NF; i++) begin
            if (m_occ[i]) pend[m_slot[i].rob]--;
            m_occ[i] = 1'b0;
            acc[i]   = 1'b0;
         end
         m_ptr = 0;
      end else begin
         for (int i = 0; i < NF; i++) begin
            acc[i] = fu_valid[i] && e_rdy[i];
            if (acc[i]) begin
               m_occ[i]  = 1'b1;
               m_slot[i] = fu_result[i];
               pend[fu_result[i].rob]++;
            end else if (granted[i]) begin
               m_occ[i] = 1'b0;
            end
         end
         if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NF;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
      #1;
   endtask

   task automatic present(input int i, input int preg, input int rob, input logic [XLEN-1:0] val);
      fu_valid[i]  = 1'b1;
      fu_result[i] = {PREG_W'(preg), ROB_W'(rob), val};
   endtask

   // Random FU behaviour: drop accepted results, start new ones with probability p.
   task automatic drive(input int p, input bit allow_zero);
      logic [PREG_W-1:0] pr;
      for (int i = 0; i < NF; i++) begin
         if (acc[i]) fu_valid[i] = 1'b0;
         if (!fu_valid[i] && ($urandom_range(99) < p)) begin
            pr = PREG_W'(i * 9 + 1 + int'($urandom_range(8)));
            if (allow_zero && $urandom_range(9) == 0) pr = '0;
            fu_valid[i]  = 1'b1;
            fu_result[i] = {pr, ROB_W'(next_rob), XLEN'($urandom)};
            next_rob     = (next_rob + 1) % 32;
         end
      end
   endtask

   // Lane {valid, preg} summary; a negative entry means the lane must be idle.
   task automatic chk_lanes(input string name, input int p0, input int p1, input int p2);
      int          ps [3];
      logic [20:0] exp_v, dut_v, mod_v;
      ps = '{p0, p1, p2};
      for (int j = 0; j < NW; j++) begin
         exp_v[j*7 +: 7] = (ps[j] < 0) ? 7'd0 : {1'b1, PREG_W'(ps[j])};
         dut_v[j*7 +: 7] = {cdb_out[j].valid, cdb_out[j].preg};
         mod_v[j*7 +: 7] = last_e_cdb[j*CW + ROB_W +: 7];
      end
      chk(name, {107'd0, dut_v}, {107'd0, exp_v});
      chk({"model_", name}, {107'd0, mod_v}, {107'd0, exp_v});
   endtask

   initial begin : stim
      logic [NW-1:0] v;
      int            nv;
      int            outstanding;
      int            p;
      for (int i = 0; i < NF; i++) fu_result[i] = '0;
      for (int i = 0; i < 32; i++) pend[i] = 0;
      for (int i = 0; i < N_PHYS_REG; i++) prf[i] = '0;
      for (int i = 0; i < NF; i++) begin
         m_occ[i] = 1'b0; acc[i] = 1'b0; m_slot[i] = '0;
      end

      // Reset held with every FU presenting.
      for (int i = 0; i < NF; i++) present(i, i + 1, i, XLEN'(i));
      repeat (2) begin
         sample();
         chk("rst_ready", {121'd0, fu_ready}, 128'd0);
         for (int j = 0; j < NW; j++) v[j] = cdb_out[j].valid;
         chk("rst_cdb_valid", {125'd0, v}, 128'd0);
         chk("rst_wb_idx", {110'd0, wb_prf_out[0].idx, wb_prf_out[1].idx, wb_prf_out[2].idx}, 128'd0);
      end
      step();
      reset = 1'b0;
      fu_valid = '0;
      sample();
      chk("post_rst_ready", {121'd0, fu_ready}, {121'd0, 7'h7F});
      chk("model_post_rst_ready", {121'd0, last_e_rdy}, {121'd0, 7'h7F});

      // Single result from FU2.
      step();
      present(2, 9, 4, 32'hDEAD_BEEF);
      sample();
      step();
      fu_valid[2] = 1'b0;
      sample();
      chk("single_cdb0", {116'd0, cdb_out[0]}, {116'd0, 1'b1, 6'd9, 5'd4});
      chk("single_wb0", {90'd0, wb_prf_out[0]}, {90'd0, 6'd9, 32'hDEAD_BEEF});
      chk("single_idle", {104'd0, cdb_out[1], cdb_out[2]}, 128'd0);
      chk("model_single", {116'd0, last_e_cdb[CW-1:0]}, {116'd0, 1'b1, 6'd9, 5'd4});
      step();
      sample();
      chk("single_prf9", {96'd0, prf[9]}, {96'd0, 32'hDEAD_BEEF});

      // Squash an empty stage to bring the scan pointer home.
      step(); squash = 1'b1;
      step(); squash = 1'b0;

      // Oversubscription: seven results, three lanes.
      for (int i = 0; i < NF; i++) present(i, i + 1, 16 + i, $urandom);
      sample();
      step(); fu_valid = '0;
      sample(); chk_lanes("over_c1", 1, 2, 3);
      step();
      sample(); chk_lanes("over_c2", 4, 5, 6);
      step();
      present(0, 11, 23, $urandom); present(1, 12, 24, $urandom); present(2, 13, 25, $urandom);
      sample(); chk_lanes("over_c3", 7, -1, -1);
      step(); fu_valid = '0;
      sample(); chk_lanes("over_c4", 11, 12, 13);
      repeat (3) step();

      // Backpressure: every FU valid every cycle.
      for (int c = 0; c < 22; c++) begin
         step();
         drive(100, 1'b0);
         sample();
         if (c >= 1) begin
            nv = 0;
            for (int j = 0; j < NW; j++) nv += int'(cdb_out[j].valid);
            chk("bp_grants", 128'(nv), 128'd3);
            chk("bp_ready_cnt", 128'($countones(fu_ready)), 128'd3);
         end
      end
      repeat (10) begin
         step();
         drive(0, 1'b0);
      end

      // Result without a destination register.
      step();
      present(5, 0, 11, 32'h1234_5678);
      sample();
      step(); fu_valid[5] = 1'b0;
      sample();
      chk("nodest_cdb0", {116'd0, cdb_out[0]}, {116'd0, 1'b1, 6'd0, 5'd11});
      chk("nodest_wb_idx", {122'd0, wb_prf_out[0].idx}, 128'd0);
      chk("nodest_idle", {104'd0, cdb_out[1], cdb_out[2]}, 128'd0);

      // Squash with five slots full and a same-cycle input.
      step();
      for (int i = 0; i < 5; i++) present(i, i + 1, 27 + i, $urandom);
      sample();
      step();
      fu_valid = '0;
      squash = 1'b1;
      present(5, 6, 26, $urandom);
      sample();
      chk_lanes("sq_cycle", -1, -1, -1);
      chk("sq_ready", {121'd0, fu_ready}, 128'd0);
      step();
      squash = 1'b0;
      fu_valid = '0;
      present(6, 7, 2, $urandom);
      present(0, 8, 3, $urandom);
      sample();
      chk("sq_next_ready", {121'd0, fu_ready}, {121'd0, 7'h7F});
      chk_lanes("sq_next_cdb", -1, -1, -1);
      step(); fu_valid = '0;
      sample();
      chk_lanes("sq_ptr_home", 8, 7, -1);
      repeat (3) step();

      // Randomized traffic with occasional squashes.
      p = 60;
      for (int c = 0; c < 400; c++) begin
         if (c % 50 == 0) p = int'($urandom_range(100));
         step();
         if (squash) begin
            squash   = 1'b0;
            fu_valid = '0;
         end else begin
            drive(p, 1'b1);
            if ($urandom_range(39) == 0) squash = 1'b1;
         end
      end
      repeat (12) begin
         step();
         drive(0, 1'b0);
      end
      sample();
      outstanding = 0;
      for (int i = 0; i < 32; i++) outstanding += pend[i];
      chk("sb_drained", 128'(outstanding), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
